// File: rtl/hue_wheel.sv
// hue_wheel: steps a colour wheel through six 60-degree sectors and decodes R/G/B duty values
// Ports:
//   clk         system clock, all state on rising edge
//   rst_n       asynchronous active-low reset, synchronous release
//   en          1 advances the step timer, 0 freezes all state
//   dir         0 rotates R->G->B, 1 rotates the other way; used only on step cycles
//   duty_r/g/b  duty values for downstream pwm stages, decoded from the registered ramp and sector
//   sector      current sector 0..5
//   sector_tick one-cycle pulse in the cycle after the edge that changed the sector
module hue_wheel #(
  parameter int PWM_INTERVAL = 1200,
  parameter int STEP_CYCLES = 1667,
  localparam int W = $clog2(PWM_INTERVAL)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         dir,
  output logic [W-1:0] duty_r,
  output logic [W-1:0] duty_g,
  output logic [W-1:0] duty_b,
  output logic [2:0]   sector,
  output logic         sector_tick
);
  localparam int TW = STEP_CYCLES > 1 ? $clog2(STEP_CYCLES) : 1;
  localparam logic [W-1:0] MAX = W'(PWM_INTERVAL - 1);
  localparam logic [W-1:0] ZERO = '0;
  localparam logic [TW-1:0] T_LAST = TW'(STEP_CYCLES - 1);
  logic [TW-1:0] t;
  logic [W-1:0] r, r_nxt, dn;
  logic [2:0] s, s_nxt;
  logic step;
  assign step = en && t == T_LAST;
  assign dn = MAX - r;
  // out-of-range sectors recover to the start of sector 1 whatever the direction
  always_comb begin
    r_nxt = r;
    s_nxt = s;
    if (s > 3'd5) begin
      r_nxt = ZERO;
      s_nxt = 3'd1;
    end else if (!dir) begin
      r_nxt = r == MAX ? ZERO : r + 1'b1;
      s_nxt = r != MAX ? s : s == 3'd5 ? 3'd0 : s + 3'd1;
    end else begin
      r_nxt = r == ZERO ? MAX : r - 1'b1;
      s_nxt = r != ZERO ? s : s == 3'd0 ? 3'd5 : s - 3'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t <= '0;
      r <= ZERO;
      s <= 3'd0;
      sector_tick <= 1'b0;
    end else begin
      if (en) t <= step ? '0 : t + 1'b1;
      if (step) begin
        r <= r_nxt;
        s <= s_nxt;
      end
      sector_tick <= step && s_nxt != s;
    end
  end
  // each sector holds one channel high, one low and ramps the third so the wheel stays continuous
  always_comb begin
    duty_r = MAX;
    duty_g = r;
    duty_b = ZERO;
    sector = s;
    case (s)
      3'd0: sector = 3'd0;
      3'd1: {duty_r, duty_g, duty_b} = {dn, MAX, ZERO};
      3'd2: {duty_r, duty_g, duty_b} = {ZERO, MAX, r};
      3'd3: {duty_r, duty_g, duty_b} = {ZERO, dn, MAX};
      3'd4: {duty_r, duty_g, duty_b} = {r, ZERO, MAX};
      3'd5: {duty_r, duty_g, duty_b} = {MAX, ZERO, dn};
      default: sector = 3'd0;
    endcase
  end
endmodule

// File: doc/hue_wheel.md
HUE_WHEEL -- requirements
Module: hue_wheel

Interface
REQ-001 SHALL have parameter PWM_INTERVAL, default 1200, meaning PWM period in clk cycles; duty width W = $clog2(PWM_INTERVAL), MAX = PWM_INTERVAL-1.
REQ-002 SHALL have parameter STEP_CYCLES, default 1667, meaning clk cycles per ramp step (about 2,000,000 cycles per 60-degree sector).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: ports clk and rst_n.
REQ-004 clk  input  1  system clock (12 MHz), all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 en  input  1  1 = advance step timer, 0 = freeze all state.
REQ-007 dir  input  1  0 = forward hue rotation (R to G to B), 1 = reverse.
REQ-008 duty_r, duty_g, duty_b  output  W each  duty values for downstream pwm stages.
REQ-009 sector  output  3  current 60-degree sector, 0..5.
REQ-010 sector_tick  output  1  one-cycle pulse on the cycle sector changes.

Function
REQ-011 SHALL hold three registers: step timer t (0..STEP_CYCLES-1), ramp r (0..MAX) and sector s (0..5).
REQ-012 en=1: t increments each cycle and wraps to 0 after STEP_CYCLES-1; a step occurs on that wrap cycle. en=0: t, r and s hold, and no step occurs.
REQ-013 Forward step: if r<MAX, r+1; if r==MAX, r=0 and s=(s+1) mod 6.
REQ-014 Reverse step: if r>0, r-1; if r==0, r=MAX and s=(s+5) mod 6.
REQ-015 dir SHALL be sampled only on step cycles; a change takes effect at the next step with no skipped or repeated value.
REQ-016 Channel modes per sector (R,G,B), with HIGH=MAX, LOW=0, UP=r, DOWN=MAX-r:
  s0 (HIGH, UP, LOW); s1 (DOWN, HIGH, LOW); s2 (LOW, HIGH, UP); s3 (LOW, DOWN, HIGH); s4 (UP, LOW, HIGH); s5 (HIGH, LOW, DOWN).
REQ-017 duty_r, duty_g, duty_b and sector SHALL be decoded from the registered r and s with no added latency, so they change on the same edge as r and s.
REQ-018 The table SHALL be continuous at every sector boundary in both directions: no channel jumps by more than 1 per step.
REQ-019 sector_tick SHALL be registered and equal 1 exactly on the cycle following the edge that changed s, otherwise 0.
REQ-020 Values of s in 6..7 SHALL be unreachable; if present, they decode as s0 and the next step goes to s=1, r=0.
REQ-021 All arithmetic SHALL be unsigned W-bit, with no overflow: DOWN is computed as MAX-r with r<=MAX.

Reset
REQ-022 While rst_n=0 (asynchronous assertion): t=0, r=0, s=0, sector_tick=0, and therefore duty_r=MAX, duty_g=0, duty_b=0.
REQ-023 Release is synchronous to clk; the first step occurs STEP_CYCLES enabled cycles after release.
REQ-024 Reset asserted mid-ramp SHALL force the reset values immediately, independent of clk.

Verification (PWM_INTERVAL=8, MAX=7, W=3, STEP_CYCLES=4)
REQ-025 Reset, then en=1, dir=0: immediately R=7, G=0, B=0, sector=0; after 4 cycles G=1; after 28 cycles G=7, R=7.
REQ-026 Boundary: after 32 enabled cycles, sector=1, R=7, G=7, B=0, sector_tick high for exactly one cycle; after 192 cycles, sector=0 and r=0, with 6 ticks counted.
REQ-027 Reverse from reset: dir=1 at the first step gives sector=5, R=7, G=0, B=0 (DOWN=MAX-7); the next step gives B=1.
REQ-028 Freeze: en=0 for 100 cycles in mid s2 with B=3: all outputs hold; with en=1 again, the next step occurs after 4 cycles counted from the frozen t value.
REQ-029 Direction flip: in s0 at G=5 set dir=1: the next steps give G=4 and then G=3, with no skip; at G=0 the next step moves to s5 with B=0.
REQ-030 Async reset pulsed mid-s3 between clock edges: outputs show R=7, G=0, B=0, sector=0 before the next clk edge.
